ddma_aipe_port: RTL and testbench
=================================

Name: ddma_aipe_port

Overview:
- Downstream neighbour of the dDMA engine's 128-bit AiPE port; sits between the engine and the AiPE local scratchpad.
- The engine issues rden/wren pulses with no grant. This block buffers them in a request FIFO and replays them to the scratchpad under a req/gnt handshake.
- Limits outstanding reads with a credit counter and returns read data in order with a registered rvalid.
- Flags protocol errors through sticky status bits.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries (power of two, >=2)
- MAX_RD_OUT, 4, maximum reads issued to scratchpad and not yet returned
- SP_AW, 12, scratchpad word-address width (128-bit words)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_dDMA_AIPE_rden  in  1  read request pulse from dDMA engine
- i_dDMA_AIPE_wren  in  1  write request pulse from dDMA engine
- i_dDMA_AIPE_addr  in  32  byte address, 16-byte aligned
- i_dDMA_AIPE_wdata  in  128  write data
- o_dDMA_AIPE_rdata  out  128  read data to engine
- o_dDMA_AIPE_rvalid  out  1  read data valid, one cycle per read
- o_fifo_full  out  1  request FIFO full
- o_busy  out  1  FIFO non-empty or reads outstanding
- i_clr_err  in  1  clears sticky error bits
- o_err_ovf  out  1  sticky: request arrived while FIFO full
- o_err_proto  out  1  sticky: rden&wren together, or stray sp_rvalid
- o_sp_req  out  1  scratchpad request
- o_sp_we  out  1  1 = write
- o_sp_addr  out  SP_AW  word address = i_dDMA_AIPE_addr[SP_AW+3:4]
- o_sp_wdata  out  128  write data
- i_sp_gnt  in  1  request accepted this cycle
- i_sp_rdata  in  128  scratchpad read data
- i_sp_rvalid  in  1  read data valid, returned in issue order

Behaviour:
- Reset (i_rst high at a clock edge):
  - All outputs 0; FIFO pointers, credit counter and sticky bits cleared; FSM to IDLE.
  - Reset mid-operation discards queued and outstanding requests. Any i_sp_rvalid in the following cycles hits credit=0 and sets o_err_proto.
- Enqueue:
  - rden xor wren with FIFO not full pushes {we, word addr, wdata} in the same cycle.
  - rden&wren together: nothing pushed; o_err_proto set next cycle.
  - Request while full (including full in that cycle with a simultaneous pop): dropped; o_err_ovf set next cycle. No bypass of a full FIFO.
- FSM states:
  - IDLE: FIFO empty, o_sp_req=0. Goes to ISSUE the cycle after the FIFO becomes non-empty. A request accepted at cycle N shows o_sp_req=1 at N+1 at the earliest.
  - ISSUE: o_sp_req/we/addr/wdata driven from a register loaded with the FIFO head. Signals are held stable until i_sp_gnt.
    - On gnt: pop; if the popped entry is a read, credit++.
    - If the next head is a read and credit==MAX_RD_OUT (after this cycle's update), go to WAIT_CREDIT.
    - Else if FIFO non-empty, stay in ISSUE with the next head loaded, giving back-to-back issue.
    - Else go to IDLE.
  - WAIT_CREDIT: o_sp_req=0. Returns to ISSUE the cycle after credit<MAX_RD_OUT. Writes queued behind the blocked read also wait; strict order is preserved.
- Credit counter:
  - Width clog2(MAX_RD_OUT+1).
  - Read grant and i_sp_rvalid in the same cycle leave credit unchanged.
  - i_sp_rvalid with credit==0: ignored, o_err_proto set, counter does not wrap.
- Read return:
  - i_sp_rvalid at cycle M gives o_dDMA_AIPE_rvalid=1 and rdata=i_sp_rdata at M+1 (registered).
  - rdata holds its last value when rvalid=0.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSBs differ and lower bits equal.
- o_busy = FIFO non-empty | credit!=0 | o_sp_req.
- i_clr_err clears both sticky bits. A new error in the same cycle wins (bit set).

Optional Feature:
- Macro: DDMA_AIPE_ALIGN_CHECK_EN.
- Defined: a request with i_dDMA_AIPE_addr[3:0]!=0 is dropped (not pushed) and o_err_proto is set next cycle.
- Undefined: addr[3:0] is ignored, the request proceeds with word address addr[SP_AW+3:4], and no error is raised.

Test Plan:
- Single write addr=0x0000_0040, wdata=0xA5..A5, i_sp_gnt held 1 -> o_sp_req high exactly 1 cycle at N+1, o_sp_we=1, o_sp_addr=0x004, o_busy low at N+2.
- 6 back-to-back reads addr 0x00,0x10..0x50, gnt=1, sp_rvalid returned 3 cycles after each grant -> exactly 4 issued before the first return, WAIT_CREDIT entered, 6 rvalid pulses in order, each 1 cycle after sp_rvalid, final credit=0.
- gnt held 0, 5 writes with FIFO_DEPTH=4 -> o_fifo_full after the 4th, 5th dropped, o_err_ovf=1. Then gnt=1 -> exactly 4 writes issued; i_clr_err -> o_err_ovf=0.
- rden&wren both 1 at addr 0x20 -> nothing issued, o_err_proto=1. Stray i_sp_rvalid while idle -> o_err_proto stays 1, no o_dDMA_AIPE_rvalid.
- i_rst asserted with 2 reads outstanding and 2 queued -> all outputs 0 next cycle; subsequent sp_rvalid produces no rvalid.
- DDMA_AIPE_ALIGN_CHECK_EN defined, write addr=0x0000_0044 -> no o_sp_req, o_err_proto=1. Undefined -> write issued with o_sp_addr=0x004, no error.

Source files
------------

// File: rtl/ddma_aipe_port.sv
// Request buffer between the dDMA engine AiPE port and the scratchpad: queues rd/wr pulses,
// replays them under req/gnt with a read-credit limit. Optional macro: DDMA_AIPE_ALIGN_CHECK_EN.
module ddma_aipe_port #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_RD_OUT = 4,
    parameter int unsigned SP_AW      = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dDMA_AIPE_rden,
    input  logic             i_dDMA_AIPE_wren,
    input  logic [31:0]      i_dDMA_AIPE_addr,
    input  logic [127:0]     i_dDMA_AIPE_wdata,
    output logic [127:0]     o_dDMA_AIPE_rdata,
    output logic             o_dDMA_AIPE_rvalid,
    output logic             o_fifo_full,
    output logic             o_busy,
    input  logic             i_clr_err,
    output logic             o_err_ovf,
    output logic             o_err_proto,
    output logic             o_sp_req,
    output logic             o_sp_we,
    output logic [SP_AW-1:0] o_sp_addr,
    output logic [127:0]     o_sp_wdata,
    input  logic             i_sp_gnt,
    input  logic [127:0]     i_sp_rdata,
    input  logic             i_sp_rvalid
);
    localparam int unsigned DW   = 128;
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTRW = PW + 1;
    localparam int unsigned CW   = $clog2(MAX_RD_OUT + 1);

    typedef struct packed {
        logic             we;
        logic [SP_AW-1:0] addr;
        logic [DW-1:0]    wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_CREDIT = 2'd2
    } state_t;

    state_t          state, state_n;
    req_t            mem [FIFO_DEPTH];
    req_t            in_req, head_n, issue_q;
    logic [PTRW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]   credit, credit_n;
    logic            fifo_full, req_one, align_ok, push, pop;
    logic            rd_inc, rd_ret, stray, ovf_evt, proto_evt;
    logic            next_nonempty, blocked, load;
    logic            sp_req_q, rvalid_q, full_q, busy_q, err_ovf_q, err_proto_q;
    logic [DW-1:0]   rdata_q;
    logic            unused_addr;

`ifdef DDMA_AIPE_ALIGN_CHECK_EN
    assign align_ok    = (i_dDMA_AIPE_addr[3:0] == 4'd0);
    assign unused_addr = ^i_dDMA_AIPE_addr[31:SP_AW+4];
`else
    assign align_ok    = 1'b1;
    assign unused_addr = ^{i_dDMA_AIPE_addr[31:SP_AW+4], i_dDMA_AIPE_addr[3:0]};
`endif

    assign in_req.we    = i_dDMA_AIPE_wren;
    assign in_req.addr  = i_dDMA_AIPE_addr[SP_AW+3:4];
    assign in_req.wdata = i_dDMA_AIPE_wdata;

    // Enqueue decisions use this cycle's occupancy, so a full FIFO never accepts even while popping
    assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign req_one   = i_dDMA_AIPE_rden ^ i_dDMA_AIPE_wren;
    assign push      = req_one & ~fifo_full & align_ok;
    assign ovf_evt   = req_one & fifo_full;
    assign pop       = sp_req_q & i_sp_gnt;

    assign rd_inc    = pop & ~issue_q.we;
    assign rd_ret    = i_sp_rvalid & (credit != '0);
    assign stray     = i_sp_rvalid & (credit == '0);
    assign proto_evt = (i_dDMA_AIPE_rden & i_dDMA_AIPE_wren) | stray | (req_one & ~align_ok);

    assign credit_n  = credit + CW'(rd_inc) - CW'(rd_ret);
    assign wr_ptr_n  = wr_ptr + PTRW'(push);
    assign rd_ptr_n  = rd_ptr + PTRW'(pop);

    // Head after this cycle's pop; an empty FIFO takes the entry being pushed right now
    assign head_n        = (rd_ptr_n != wr_ptr) ? mem[rd_ptr_n[PW-1:0]] : in_req;
    assign next_nonempty = (rd_ptr_n != wr_ptr) | push;
    assign blocked       = ~head_n.we & (credit_n == CW'(MAX_RD_OUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (next_nonempty) begin
                    if (blocked) begin
                        state_n = WAIT_CREDIT;
                    end else begin
                        state_n = ISSUE;
                        load    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (i_sp_gnt) begin
                    if (!next_nonempty) begin
                        state_n = IDLE;
                    end else if (blocked) begin
                        state_n = WAIT_CREDIT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            WAIT_CREDIT: begin
                if (credit < CW'(MAX_RD_OUT)) begin
                    state_n = ISSUE;
                    load    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= in_req;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            credit      <= '0;
            issue_q     <= '0;
            sp_req_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_proto_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            credit      <= credit_n;
            if (load) issue_q <= head_n;
            sp_req_q    <= (state_n == ISSUE);
            rvalid_q    <= rd_ret;
            if (rd_ret) rdata_q <= i_sp_rdata;
            full_q      <= (wr_ptr_n[PW] != rd_ptr_n[PW]) &&
                           (wr_ptr_n[PW-1:0] == rd_ptr_n[PW-1:0]);
            busy_q      <= (wr_ptr_n != rd_ptr_n) | (credit_n != '0) | (state_n == ISSUE);
            err_ovf_q   <= ovf_evt | (err_ovf_q & ~i_clr_err);
            err_proto_q <= proto_evt | (err_proto_q & ~i_clr_err);
        end
    end

    assign o_sp_req           = sp_req_q;
    assign o_sp_we            = issue_q.we;
    assign o_sp_addr          = issue_q.addr;
    assign o_sp_wdata         = issue_q.wdata;
    assign o_dDMA_AIPE_rvalid = rvalid_q;
    assign o_dDMA_AIPE_rdata  = rdata_q;
    assign o_fifo_full        = full_q;
    assign o_busy             = busy_q;
    assign o_err_ovf          = err_ovf_q;
    assign o_err_proto        = err_proto_q;

endmodule

// File: tb/tb_ddma_aipe_port.sv
// Directed bench for ddma_aipe_port with a scratchpad model returning reads
// four cycles after their grant (three idle cycles in between).
module tb_ddma_aipe_port;
    localparam int unsigned SP_AW = 12;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_dDMA_AIPE_rden = 1'b0;
    logic             i_dDMA_AIPE_wren = 1'b0;
    logic [31:0]      i_dDMA_AIPE_addr = '0;
    logic [127:0]     i_dDMA_AIPE_wdata = '0;
    logic [127:0]     o_dDMA_AIPE_rdata;
    logic             o_dDMA_AIPE_rvalid;
    logic             o_fifo_full;
    logic             o_busy;
    logic             i_clr_err = 1'b0;
    logic             o_err_ovf;
    logic             o_err_proto;
    logic             o_sp_req;
    logic             o_sp_we;
    logic [SP_AW-1:0] o_sp_addr;
    logic [127:0]     o_sp_wdata;
    logic             i_sp_gnt = 1'b0;
    logic [127:0]     i_sp_rdata = '0;
    logic             i_sp_rvalid = 1'b0;

    ddma_aipe_port #(.FIFO_DEPTH(4), .MAX_RD_OUT(4), .SP_AW(SP_AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_dDMA_AIPE_rden(i_dDMA_AIPE_rden), .i_dDMA_AIPE_wren(i_dDMA_AIPE_wren),
        .i_dDMA_AIPE_addr(i_dDMA_AIPE_addr), .i_dDMA_AIPE_wdata(i_dDMA_AIPE_wdata),
        .o_dDMA_AIPE_rdata(o_dDMA_AIPE_rdata), .o_dDMA_AIPE_rvalid(o_dDMA_AIPE_rvalid),
        .o_fifo_full(o_fifo_full), .o_busy(o_busy), .i_clr_err(i_clr_err),
        .o_err_ovf(o_err_ovf), .o_err_proto(o_err_proto),
        .o_sp_req(o_sp_req), .o_sp_we(o_sp_we), .o_sp_addr(o_sp_addr), .o_sp_wdata(o_sp_wdata),
        .i_sp_gnt(i_sp_gnt), .i_sp_rdata(i_sp_rdata), .i_sp_rvalid(i_sp_rvalid)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;
    int rd_grants = 0;
    int wr_grants = 0;
    int rv_count = 0;
    int first_ret = -1;
    logic chk_rv = 1'b0;
    logic saw_gap = 1'b0;
    logic [SP_AW-1:0] last_addr = '0;
    logic v [3] = '{1'b0, 1'b0, 1'b0};
    logic [127:0] d [3] = '{128'd0, 128'd0, 128'd0};

    function automatic logic [127:0] mkdata(input logic [SP_AW-1:0] a);
        return {4{32'hC0DE_0000 | 32'(a)}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: account grants, advance the scratchpad return pipe, check read returns
    task automatic tick();
        logic g;
        logic prv;
        logic [SP_AW-1:0] ga;
        if (i_sp_rvalid && first_ret < 0) first_ret = rd_grants;
        prv = i_sp_rvalid;
        g   = o_sp_req & i_sp_gnt & ~o_sp_we;
        ga  = o_sp_addr;
        if (o_sp_req && i_sp_gnt) begin
            if (o_sp_we) wr_grants++;
            else         rd_grants++;
            last_addr = o_sp_addr;
        end
        if (chk_rv && !o_sp_req && rd_grants > 0 && rd_grants < 6) saw_gap = 1'b1;
        @(posedge i_clk);
        #1;
        i_sp_rvalid = v[2];
        i_sp_rdata  = d[2];
        v[2] = v[1]; d[2] = d[1];
        v[1] = v[0]; d[1] = d[0];
        v[0] = g;    d[0] = mkdata(ga);
        if (o_dDMA_AIPE_rvalid) rv_count++;
        if (chk_rv) begin
            check("rvalid_latency", 128'(o_dDMA_AIPE_rvalid), 128'(prv));
            if (o_dDMA_AIPE_rvalid)
                check("rdata_order", o_dDMA_AIPE_rdata, mkdata(SP_AW'(rv_count - 1)));
        end
    endtask

    task automatic idle_inputs();
        i_dDMA_AIPE_rden = 1'b0;
        i_dDMA_AIPE_wren = 1'b0;
        i_clr_err        = 1'b0;
    endtask

    initial begin
        // Reset state
        i_rst = 1'b1;
        tick(); tick();
        check("rst_req", 128'(o_sp_req), 128'd0);
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_full", 128'(o_fifo_full), 128'd0);
        check("rst_errs", 128'({o_err_ovf, o_err_proto}), 128'd0);
        check("rst_rvalid", 128'(o_dDMA_AIPE_rvalid), 128'd0);
        i_rst = 1'b0;
        tick();

        // Single write, grant held high
        i_sp_gnt = 1'b1;
        i_dDMA_AIPE_wren  = 1'b1;
        i_dDMA_AIPE_addr  = 32'h0000_0040;
        i_dDMA_AIPE_wdata = {16{8'hA5}};
        check("wr1_req_n", 128'(o_sp_req), 128'd0);
        tick();
        idle_inputs();
        check("wr1_req_n1", 128'(o_sp_req), 128'd1);
        check("wr1_we", 128'(o_sp_we), 128'd1);
        check("wr1_addr", 128'(o_sp_addr), 128'h004);
        check("wr1_wdata", o_sp_wdata, {16{8'hA5}});
        check("wr1_busy_n1", 128'(o_busy), 128'd1);
        tick();
        check("wr1_req_n2", 128'(o_sp_req), 128'd0);
        check("wr1_busy_n2", 128'(o_busy), 128'd0);

        // Six back-to-back reads against the credit limit
        rd_grants = 0; rv_count = 0; first_ret = -1; saw_gap = 1'b0;
        chk_rv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_dDMA_AIPE_rden = 1'b1;
            i_dDMA_AIPE_addr = 32'(i * 16);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) tick();
        chk_rv = 1'b0;
        check("rd_before_first_ret", 128'(first_ret), 128'd4);
        check("rd_credit_stall", 128'(saw_gap), 128'd1);
        check("rd_grants", 128'(rd_grants), 128'd6);
        check("rd_rvalid_count", 128'(rv_count), 128'd6);
        check("rd_credit_zero", 128'(o_busy), 128'd0);
        check("rd_rdata_hold", o_dDMA_AIPE_rdata, mkdata(SP_AW'(5)));
        check("rd_no_err", 128'({o_err_ovf, o_err_proto}), 128'd0);

        // Overflow with grant held low, then a drop while full with a simultaneous pop
        i_sp_gnt = 1'b0;
        wr_grants = 0;
        for (int i = 0; i < 4; i++) begin
            i_dDMA_AIPE_wren  = 1'b1;
            i_dDMA_AIPE_addr  = 32'((i + 1) * 256);
            i_dDMA_AIPE_wdata = 128'(i + 1);
            tick();
        end
        check("ovf_full_after4", 128'(o_fifo_full), 128'd1);
        check("ovf_not_yet", 128'(o_err_ovf), 128'd0);
        i_dDMA_AIPE_addr = 32'h0000_0500;
        tick();
        idle_inputs();
        check("ovf_set", 128'(o_err_ovf), 128'd1);
        check("ovf_still_full", 128'(o_fifo_full), 128'd1);
        i_clr_err = 1'b1;
        tick();
        idle_inputs();
        check("ovf_cleared", 128'(o_err_ovf), 128'd0);
        i_sp_gnt = 1'b1;
        i_dDMA_AIPE_wren = 1'b1;
        i_dDMA_AIPE_addr = 32'h0000_0600;
        tick();
        idle_inputs();
        check("ovf_full_pop_drop", 128'(o_err_ovf), 128'd1);
        check("ovf_full_drops", 128'(o_fifo_full), 128'd0);
        for (int i = 0; i < 6; i++) tick();
        check("ovf_wr_grants", 128'(wr_grants), 128'd4);
        check("ovf_last_addr", 128'(last_addr), 128'h040);
        i_clr_err = 1'b1;
        tick();
        idle_inputs();
        check("ovf_clr", 128'(o_err_ovf), 128'd0);
        check("ovf_idle", 128'(o_busy), 128'd0);

        // rden and wren together, then a stray scratchpad return
        rd_grants = 0; wr_grants = 0; rv_count = 0;
        i_dDMA_AIPE_rden = 1'b1;
        i_dDMA_AIPE_wren = 1'b1;
        i_dDMA_AIPE_addr = 32'h0000_0020;
        tick();
        idle_inputs();
        check("both_proto", 128'(o_err_proto), 128'd1);
        tick(); tick();
        check("both_nothing_issued", 128'(rd_grants + wr_grants), 128'd0);
        check("both_not_busy", 128'(o_busy), 128'd0);
        i_clr_err = 1'b1;
        tick();
        idle_inputs();
        check("proto_clr", 128'(o_err_proto), 128'd0);
        i_sp_rvalid = 1'b1;
        i_sp_rdata  = {4{32'hDEAD_BEEF}};
        tick();
        check("stray_proto", 128'(o_err_proto), 128'd1);
        check("stray_no_rvalid", 128'(o_dDMA_AIPE_rvalid), 128'd0);
        i_clr_err = 1'b1;
        i_dDMA_AIPE_rden = 1'b1;
        i_dDMA_AIPE_wren = 1'b1;
        tick();
        idle_inputs();
        check("clr_vs_new_err", 128'(o_err_proto), 128'd1);
        check("stray_rv_total", 128'(rv_count), 128'd0);
        i_clr_err = 1'b1;
        tick();
        idle_inputs();
        check("proto_clr2", 128'(o_err_proto), 128'd0);

        // Reset with two reads outstanding and two queued
        for (int i = 0; i < 4; i++) begin
            i_sp_gnt = (i < 3);
            i_dDMA_AIPE_rden = 1'b1;
            i_dDMA_AIPE_addr = 32'(16 * (i + 8));
            tick();
        end
        idle_inputs();
        i_sp_gnt = 1'b0;
        check("pre_rst_busy", 128'(o_busy), 128'd1);
        rv_count = 0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("mid_rst_req", 128'(o_sp_req), 128'd0);
        check("mid_rst_sp_bus", 128'({o_sp_we, o_sp_addr}), 128'd0);
        check("mid_rst_wdata", o_sp_wdata, 128'd0);
        check("mid_rst_rdata", o_dDMA_AIPE_rdata, 128'd0);
        check("mid_rst_flags", 128'({o_busy, o_fifo_full, o_err_ovf, o_err_proto}), 128'd0);
        tick(); tick(); tick();
        check("post_rst_no_rvalid", 128'(rv_count), 128'd0);
        check("post_rst_proto", 128'(o_err_proto), 128'd1);
        check("post_rst_idle", 128'({o_sp_req, o_busy}), 128'd0);
        i_clr_err = 1'b1;
        tick();
        idle_inputs();

        // Misaligned write
        wr_grants = 0;
        i_sp_gnt = 1'b1;
        i_dDMA_AIPE_wren  = 1'b1;
        i_dDMA_AIPE_addr  = 32'h0000_0044;
        i_dDMA_AIPE_wdata = {4{32'h1234_5678}};
        tick();
        idle_inputs();
`ifdef DDMA_AIPE_ALIGN_CHECK_EN
        check("align_no_req", 128'(o_sp_req), 128'd0);
        check("align_proto", 128'(o_err_proto), 128'd1);
        tick();
        check("align_no_grant", 128'(wr_grants), 128'd0);
`else
        check("align_req", 128'(o_sp_req), 128'd1);
        check("align_addr", 128'(o_sp_addr), 128'h004);
        check("align_no_proto", 128'(o_err_proto), 128'd0);
        tick();
        check("align_grant", 128'(wr_grants), 128'd1);
`endif
        check("align_idle", 128'(o_busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
